// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, start-bit glitch rejection, stop-bit framing error.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
//
// state           | meaning
// s_IDLE          | line idle, counters cleared, waiting for a low on r_Rx
// s_RX_START_BIT  | timing to mid start bit; high there means a glitch
// s_RX_DATA_BITS  | sampling 8 data bits, LSB first
// s_RX_STOP_BIT   | sampling stop bit; low means framing error
// s_CLEANUP       | one cycle to drop the valid strobe
// s_WAIT_IDLE     | after a framing error, wait for the line to return high
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err
);

    typedef enum logic [2:0] {
        s_IDLE,
        s_RX_START_BIT,
        s_RX_DATA_BITS,
        s_RX_STOP_BIT,
        s_CLEANUP,
        s_WAIT_IDLE
    } state_t;

    // With voting, the decision is made one cycle late (at T+1, which is count 0 of the
    // next bit), so terminal counts grow by one and each new bit starts counting at 1.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] VOTE_LAG = 16'd1;
`else
    localparam logic [15:0] VOTE_LAG = 16'd0;
`endif
    localparam logic [15:0] HALF_TC = 16'((CLKS_PER_BIT - 1) / 2) + VOTE_LAG;
    localparam logic [15:0] BIT_TC  = 16'(CLKS_PER_BIT - 1) + VOTE_LAG;

    state_t      state;
    logic        rx_meta;
    logic        r_Rx;
    logic        sample;
    logic [15:0] clock_count;
    logic [2:0]  bit_index;
    logic [7:0]  rx_shift;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_meta <= 1'b1;
            r_Rx    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            r_Rx    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], r_Rx};
        end
    end

    assign sample = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & r_Rx) | (rx_hist[0] & r_Rx);
`else
    assign sample = r_Rx;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= s_IDLE;
            clock_count <= 16'd0;
            bit_index   <= 3'd0;
            rx_shift    <= 8'h00;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= 8'h00;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            case (state)
                s_IDLE: begin
                    clock_count <= 16'd0;
                    bit_index   <= 3'd0;
                    if (!r_Rx) begin
                        o_Rx_Active <= 1'b1;
                        state       <= s_RX_START_BIT;
                    end else begin
                        o_Rx_Active <= 1'b0;
                    end
                end

                s_RX_START_BIT: begin
                    if (clock_count == HALF_TC) begin
                        clock_count <= VOTE_LAG;
                        if (!sample) begin
                            state <= s_RX_DATA_BITS;
                        end else begin
                            o_Rx_Active <= 1'b0;
                            state       <= s_IDLE;
                        end
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end

                s_RX_DATA_BITS: begin
                    if (clock_count == BIT_TC) begin
                        clock_count         <= VOTE_LAG;
                        rx_shift[bit_index] <= sample;
                        if (bit_index < 3'd7) begin
                            bit_index <= bit_index + 3'd1;
                        end else begin
                            bit_index <= 3'd0;
                            state     <= s_RX_STOP_BIT;
                        end
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end

                s_RX_STOP_BIT: begin
                    if (clock_count == BIT_TC) begin
                        clock_count <= 16'd0;
                        o_Rx_Active <= 1'b0;
                        if (sample) begin
                            o_Rx_Byte <= rx_shift;
                            o_Rx_DV   <= 1'b1;
                            state     <= s_CLEANUP;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            state       <= s_WAIT_IDLE;
                        end
                    end else begin
                        clock_count <= clock_count + 16'd1;
                    end
                end

                s_CLEANUP: begin
                    o_Rx_DV <= 1'b0;
                    state   <= s_IDLE;
                end

                // A held-low break stays here rather than being decoded as frames.
                s_WAIT_IDLE: begin
                    o_Frame_Err <= 1'b0;
                    if (r_Rx) begin
                        state <= s_IDLE;
                    end
                end

                default: begin
                    state <= s_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit; works with or without UART_RX_MAJORITY_EN.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       dv;
    logic [7:0] rx_byte;
    logic       active;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int dv_count = 0;
    int ferr_count = 0;
    int active_cycles = 0;
    int dv_cyc = 0;
    int start_cyc = 0;
    int d0;
    int f0;
    logic [7:0] rx_bytes[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (dv),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Active (active),
        .o_Frame_Err (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (dv) begin
                dv_count = dv_count + 1;
                dv_cyc   = cyc;
                rx_bytes.push_back(rx_byte);
            end
            if (frame_err) ferr_count = ferr_count + 1;
            if (active) active_cycles = active_cycles + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    // Drives ncyc cycles of a frame; glitch_at forces the line low for that one cycle.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_at,
                              input int ncyc);
        int   bitn;
        logic v;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bitn = c / CPB;
            if (bitn == 0)      v = 1'b0;
            else if (bitn == 9) v = stop;
            else                v = data[bitn-1];
            if (c == glitch_at) v = 1'b0;
            if (c == 0) start_cyc = cyc;
            rx = v;
        end
    endtask

    task automatic send_byte(input logic [7:0] data);
        send_frame(data, 1'b1, -1, 10 * CPB);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_dv", 32'(dv), 32'h0);
        chk("rst_byte", 32'(rx_byte), 32'h00);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        hold(1'b1, 8);

        // Single byte 0xA5
        d0 = dv_count; f0 = ferr_count; active_cycles = 0;
        send_byte(8'hA5);
        hold(1'b1, 20);
        chk("a5_dv_count", 32'(dv_count - d0), 32'd1);
        chk("a5_byte", 32'(rx_byte), 32'hA5);
        chk("a5_ferr", 32'(ferr_count - f0), 32'd0);
        chk("a5_active_len", 32'(active_cycles >= 144 && active_cycles <= 160), 32'd1);
        chk("a5_latency", 32'((dv_cyc - start_cyc) >= 152 && (dv_cyc - start_cyc) <= 158), 32'd1);
        chk("a5_active_end", 32'(active), 32'h0);

        // Back-to-back 0x00 then 0xFF
        d0 = dv_count; rx_bytes.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        hold(1'b1, 20);
        chk("b2b_dv_count", 32'(dv_count - d0), 32'd2);
        chk("b2b_first", (rx_bytes.size() > 0) ? 32'(rx_bytes[0]) : 32'hDEAD, 32'h00);
        chk("b2b_second", (rx_bytes.size() > 1) ? 32'(rx_bytes[1]) : 32'hDEAD, 32'hFF);

        // 4-cycle glitch on idle line
        d0 = dv_count; f0 = ferr_count; active_cycles = 0;
        hold(1'b0, 4);
        hold(1'b1, 60);
        chk("glitch_dv", 32'(dv_count - d0), 32'd0);
        chk("glitch_ferr", 32'(ferr_count - f0), 32'd0);
        chk("glitch_active_seen", 32'(active_cycles > 0), 32'd1);
        chk("glitch_active_brief", 32'(active_cycles < CPB), 32'd1);
        chk("glitch_active_end", 32'(active), 32'h0);
        chk("glitch_byte_kept", 32'(rx_byte), 32'hFF);

        // Framing error on 0x3C followed by a 40-bit break
        d0 = dv_count; f0 = ferr_count;
        send_frame(8'h3C, 1'b0, -1, 10 * CPB);
        hold(1'b0, 40 * CPB);
        chk("ferr_count", 32'(ferr_count - f0), 32'd1);
        chk("ferr_no_dv", 32'(dv_count - d0), 32'd0);
        chk("ferr_byte_kept", 32'(rx_byte), 32'hFF);
        hold(1'b1, 40);
        chk("ferr_after_break", 32'(ferr_count - f0), 32'd1);
        chk("ferr_after_break_dv", 32'(dv_count - d0), 32'd0);
        send_byte(8'h42);
        hold(1'b1, 20);
        chk("recover_dv", 32'(dv_count - d0), 32'd1);
        chk("recover_byte", 32'(rx_byte), 32'h42);

        // Reset during bit 4 of 0x5A, then 0x81
        d0 = dv_count; f0 = ferr_count;
        send_frame(8'h5A, 1'b1, -1, 5 * CPB + CPB / 2);
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        hold(1'b1, 3);
        chk("abort_byte", 32'(rx_byte), 32'h00);
        chk("abort_active", 32'(active), 32'h0);
        rst_n = 1'b1;
        hold(1'b1, 30);
        chk("abort_no_dv", 32'(dv_count - d0), 32'd0);
        chk("abort_no_ferr", 32'(ferr_count - f0), 32'd0);
        send_byte(8'h81);
        hold(1'b1, 20);
        chk("post_abort_dv", 32'(dv_count - d0), 32'd1);
        chk("post_abort_byte", 32'(rx_byte), 32'h81);

        // One-cycle low glitch at mid-bit of data bit 2 in 0xFF
        d0 = dv_count;
        send_frame(8'hFF, 1'b1, 3 * CPB + CPB / 2, 10 * CPB);
        hold(1'b1, 20);
        chk("midbit_dv", 32'(dv_count - d0), 32'd1);
`ifdef UART_RX_MAJORITY_EN
        chk("midbit_byte", 32'(rx_byte), 32'hFF);
`else
        chk("midbit_byte", 32'(rx_byte), 32'hFB);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
